// File: rtl/fft16_pkg.sv
// rtl/fft16_pkg.sv - shared constants, state encoding and bin index helpers for the 16-point FFT frame sequencer
package fft16_pkg;

   localparam int N_POINT = 16;
   localparam int LOG4_N  = 2;

   function automatic int res_width(input int data_width, input int wn_width);
      return data_width + wn_width + 2;
   endfunction

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_UNLOAD = 2'd2
   } state_t;

   // Radix-4 output ordering: bin k lives in result slot {k[1:0], k[3:2]}.
   function automatic logic [3:0] digit_rev4(input logic [3:0] k);
      return {k[1:0], k[3:2]};
   endfunction

endpackage

// File: rtl/fft16_result_buf.sv
// rtl/fft16_result_buf.sv - 16-slot capture register for datapath results with digit-reversed read port
module fft16_result_buf
   import fft16_pkg::*;
#(
   parameter int RES_WIDTH = 18
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           capture,
   input  logic [RES_WIDTH*N_POINT-1:0]   xk_real,
   input  logic [RES_WIDTH*N_POINT-1:0]   xk_imag,
   input  logic [3:0]                     rd_bin,
   output logic [RES_WIDTH-1:0]           rd_real,
   output logic [RES_WIDTH-1:0]           rd_imag
);

   logic [RES_WIDTH-1:0] res_real [N_POINT];
   logic [RES_WIDTH-1:0] res_imag [N_POINT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < N_POINT; j++) begin
            res_real[j] <= '0;
            res_imag[j] <= '0;
         end
      end else if (capture) begin
         for (int j = 0; j < N_POINT; j++) begin
            res_real[j] <= xk_real[RES_WIDTH*j +: RES_WIDTH];
            res_imag[j] <= xk_imag[RES_WIDTH*j +: RES_WIDTH];
         end
      end
   end

   assign rd_real = res_real[digit_rev4(rd_bin)];
   assign rd_imag = res_imag[digit_rev4(rd_bin)];

endmodule

// File: rtl/fft16_frame_ctrl.sv
// rtl/fft16_frame_ctrl.sv - frame sequencer: serial load, datapath latency wait, capture, natural-order unload
module fft16_frame_ctrl
   import fft16_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int Wn_WIDTH   = 8,
   parameter int N_POINT    = 16,
   parameter int PIPE_LAT   = 2,
   localparam int RES_WIDTH = res_width(DATA_WIDTH, Wn_WIDTH)
)(
   input  logic                            sys_clk_i,
   input  logic                            sys_rst_i,
   input  logic                            s_valid_i,
   output logic                            s_ready_o,
   input  logic [DATA_WIDTH-1:0]           s_real_i,
   input  logic [DATA_WIDTH-1:0]           s_imag_i,
   output logic [DATA_WIDTH*N_POINT-1:0]   dp_xn_real_o,
   output logic [DATA_WIDTH*N_POINT-1:0]   dp_xn_imag_o,
   input  logic [RES_WIDTH*N_POINT-1:0]    dp_xk_real_i,
   input  logic [RES_WIDTH*N_POINT-1:0]    dp_xk_imag_i,
   output logic                            m_valid_o,
   input  logic                            m_ready_i,
   output logic [RES_WIDTH-1:0]            m_real_o,
   output logic [RES_WIDTH-1:0]            m_imag_o,
   output logic [3:0]                      m_index_o,
   output logic                            m_last_o,
   output logic                            busy_o
);

   localparam int IDX_W = 2 * LOG4_N;
   localparam logic [IDX_W-1:0] LAST_IDX = '1;

   generate
      if (N_POINT != fft16_pkg::N_POINT) begin : g_bad_n_point
         $error("fft16_frame_ctrl: N_POINT must be 16");
      end
      if (PIPE_LAT < 0 || PIPE_LAT > 15) begin : g_bad_pipe_lat
         $error("fft16_frame_ctrl: PIPE_LAT must be in 0..15");
      end
   endgenerate

   state_t                  state;
   state_t                  state_nxt;
   logic [IDX_W-1:0]        in_cnt;
   logic [IDX_W-1:0]        out_cnt;
   logic [3:0]              lat_cnt;
   logic                    capture;
   logic                    in_fire;
   logic                    out_fire;
   logic [RES_WIDTH-1:0]    rd_real;
   logic [RES_WIDTH-1:0]    rd_imag;

   logic [DATA_WIDTH-1:0]   xn_real [N_POINT];
   logic [DATA_WIDTH-1:0]   xn_imag [N_POINT];

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state <= ST_LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake-facing flags depend on state only, so ready/valid never loop back combinationally.
   always_comb begin
      state_nxt = state;
      s_ready_o = 1'b0;
      m_valid_o = 1'b0;
      busy_o    = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_LOAD: begin
            s_ready_o = 1'b1;
            if (s_valid_i && in_cnt == LAST_IDX) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            busy_o = 1'b1;
            if (lat_cnt == 4'd0) begin
               capture   = 1'b1;
               state_nxt = ST_UNLOAD;
            end
         end
         ST_UNLOAD: begin
            busy_o    = 1'b1;
            m_valid_o = 1'b1;
            if (m_ready_i && out_cnt == LAST_IDX) begin
               state_nxt = ST_LOAD;
            end
         end
         default: begin
            state_nxt = ST_LOAD;
         end
      endcase
   end

   assign in_fire  = s_valid_i & s_ready_o;
   assign out_fire = m_valid_o & m_ready_i;

   // Counters wrap through their natural 4-bit width at the frame boundary.
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         in_cnt  <= '0;
         out_cnt <= '0;
         lat_cnt <= '0;
      end else begin
         if (in_fire) begin
            in_cnt <= in_cnt + 1'b1;
         end
         if (in_fire && in_cnt == LAST_IDX) begin
            lat_cnt <= 4'(PIPE_LAT);
         end else if (state == ST_WAIT && lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
         if (out_fire) begin
            out_cnt <= out_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         for (int i = 0; i < N_POINT; i++) begin
            xn_real[i] <= '0;
            xn_imag[i] <= '0;
         end
      end else if (in_fire) begin
         xn_real[in_cnt] <= s_real_i;
         xn_imag[in_cnt] <= s_imag_i;
      end
   end

   for (genvar i = 0; i < N_POINT; i++) begin : g_xn
      assign dp_xn_real_o[DATA_WIDTH*i +: DATA_WIDTH] = xn_real[i];
      assign dp_xn_imag_o[DATA_WIDTH*i +: DATA_WIDTH] = xn_imag[i];
   end

   fft16_result_buf #(
      .RES_WIDTH (RES_WIDTH)
   ) u_result_buf (
      .clk       (sys_clk_i),
      .rst       (sys_rst_i),
      .capture   (capture),
      .xk_real   (dp_xk_real_i),
      .xk_imag   (dp_xk_imag_i),
      .rd_bin    (out_cnt),
      .rd_real   (rd_real),
      .rd_imag   (rd_imag)
   );

   // Result data is only presented while a bin is being offered.
   assign m_real_o  = m_valid_o ? rd_real : '0;
   assign m_imag_o  = m_valid_o ? rd_imag : '0;
   assign m_index_o = out_cnt;
   assign m_last_o  = m_valid_o && (out_cnt == LAST_IDX);

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// tb/tb_fft16_frame_ctrl.sv - self-checking bench for fft16_frame_ctrl with a delayed sign-extending stub datapath
module tb_fft16_frame_ctrl;

   localparam int DW = 8;
   localparam int WW = 8;
   localparam int NP = 16;
   localparam int PL = 2;
   localparam int RW = DW + WW + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DW-1:0]     s_real = '0;
   logic [DW-1:0]     s_imag = '0;
   logic [DW*NP-1:0]  xn_real, xn_imag;
   logic [RW*NP-1:0]  xk_real, xk_imag;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [RW-1:0]     m_real, m_imag;
   logic [3:0]        m_index;
   logic              m_last;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fft16_frame_ctrl #(
      .DATA_WIDTH (DW),
      .Wn_WIDTH   (WW),
      .N_POINT    (NP),
      .PIPE_LAT   (PL)
   ) dut (
      .sys_clk_i    (clk),
      .sys_rst_i    (rst),
      .s_valid_i    (s_valid),
      .s_ready_o    (s_ready),
      .s_real_i     (s_real),
      .s_imag_i     (s_imag),
      .dp_xn_real_o (xn_real),
      .dp_xn_imag_o (xn_imag),
      .dp_xk_real_i (xk_real),
      .dp_xk_imag_i (xk_imag),
      .m_valid_o    (m_valid),
      .m_ready_i    (m_ready),
      .m_real_o     (m_real),
      .m_imag_o     (m_imag),
      .m_index_o    (m_index),
      .m_last_o     (m_last),
      .busy_o       (busy)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Stub datapath: result slot j is input slot j sign-extended, delayed PL cycles.
   function automatic logic [RW*NP-1:0] sext_all(input logic [DW*NP-1:0] x);
      logic [RW*NP-1:0] r;
      r = '0;
      for (int j = 0; j < NP; j++) r[RW*j +: RW] = RW'($signed(x[DW*j +: DW]));
      return r;
   endfunction

   logic [RW*NP-1:0] pipe_re [PL];
   logic [RW*NP-1:0] pipe_im [PL];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < PL; k++) begin
            pipe_re[k] <= '0;
            pipe_im[k] <= '0;
         end
      end else begin
         pipe_re[0] <= sext_all(xn_real);
         pipe_im[0] <= sext_all(xn_imag);
         for (int k = 1; k < PL; k++) begin
            pipe_re[k] <= pipe_re[k-1];
            pipe_im[k] <= pipe_im[k-1];
         end
      end
   end
   assign xk_real = pipe_re[PL-1];
   assign xk_imag = pipe_im[PL-1];

   // Frame model: count accepted samples, edges waited since the frame filled, bins delivered.
   logic signed [DW-1:0] mdl_re [NP];
   logic signed [DW-1:0] mdl_im [NP];
   int n_in = 0;
   int n_out = 0;
   int wait_cnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n_in <= 0;
         n_out <= 0;
         wait_cnt <= 0;
         for (int i = 0; i < NP; i++) begin
            mdl_re[i] <= '0;
            mdl_im[i] <= '0;
         end
      end else if (n_in < NP) begin
         if (s_valid) begin
            mdl_re[n_in] <= s_real;
            mdl_im[n_in] <= s_imag;
            n_in <= n_in + 1;
            wait_cnt <= 0;
         end
      end else if (wait_cnt < PL + 1) begin
         wait_cnt <= wait_cnt + 1;
      end else if (m_ready) begin
         if (n_out == NP - 1) begin
            n_in <= 0;
            n_out <= 0;
         end else begin
            n_out <= n_out + 1;
         end
      end
   end

   int out_hs = 0;
   int got_idx [32];
   longint got_re [32];
   longint got_im [32];
   bit got_last [32];
   int in_hs_edge = 0;
   int last_hs_edge = 0;
   int rise_cyc = 0;
   bit prev_valid = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         bit mv;
         int j;
         mv = (n_in == NP) && (wait_cnt >= PL + 1);
         chk("s_ready", s_ready, n_in < NP);
         chk("busy", busy, n_in == NP);
         chk("m_valid", m_valid, mv);
         chk("m_last", m_last, mv && n_out == NP - 1);
         if (mv) begin
            j = (n_out % 4) * 4 + n_out / 4;
            chk("m_index", m_index, n_out);
            chk("m_real", $signed(m_real), mdl_re[j]);
            chk("m_imag", $signed(m_imag), mdl_im[j]);
         end
         for (int i = 0; i < NP; i++) begin
            chk($sformatf("dp_xn_real[%0d]", i), $signed(xn_real[DW*i +: DW]), mdl_re[i]);
            chk($sformatf("dp_xn_imag[%0d]", i), $signed(xn_imag[DW*i +: DW]), mdl_im[i]);
         end
         if (m_valid && m_ready) begin
            if (out_hs < 32) begin
               got_idx[out_hs] = m_index;
               got_re[out_hs] = $signed(m_real);
               got_im[out_hs] = $signed(m_imag);
               got_last[out_hs] = m_last;
            end
            out_hs++;
            if (m_last) last_hs_edge = cyc + 1;
         end
         if (s_valid && s_ready) in_hs_edge = cyc + 1;
         if (m_valid && !prev_valid) rise_cyc = cyc;
         prev_valid = m_valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   logic [DW-1:0] stim_re [NP];
   logic [DW-1:0] stim_im [NP];

   task automatic drive_frame(input bit gaps, input bit hold_valid);
      int i;
      int guard;
      bit tog;
      bit hs;
      i = 0;
      guard = 0;
      tog = 1'b1;
      while (i < NP && guard < 200) begin
         s_valid = gaps ? tog : 1'b1;
         tog = ~tog;
         s_real = stim_re[i];
         s_imag = stim_im[i];
         @(negedge clk);
         hs = s_valid && s_ready;
         @(posedge clk);
         #1;
         if (hs) i++;
         guard++;
      end
      if (!hold_valid) s_valid = 1'b0;
      chk("load_done", i, NP);
   endtask

   task automatic drain(input int stall_at, input int stall_len);
      int guard;
      bit stalled;
      guard = 0;
      stalled = 1'b0;
      m_ready = 1'b1;
      while (out_hs < NP && guard < 300) begin
         if (!stalled && m_valid && int'(m_index) == stall_at) begin
            stalled = 1'b1;
            m_ready = 1'b0;
            for (int c = 0; c < stall_len; c++) begin
               @(negedge clk);
               chk("stall_index", m_index, stall_at);
               chk("stall_valid", m_valid, 1);
               @(posedge clk);
               #1;
            end
            m_ready = 1'b1;
         end
         @(posedge clk);
         #1;
         guard++;
      end
      chk("drain_count", out_hs, NP);
   endtask

   task automatic check_order();
      for (int k = 0; k < NP; k++) chk($sformatf("bin_order[%0d]", k), got_idx[k], k);
   endtask

   initial begin
      int guard;
      int l4;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_index", m_index, 0);
      chk("rst_m_real", m_real, 0);
      chk("rst_xn_zero", (xn_real == '0) && (xn_imag == '0), 1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Frame 1: slot mapping, latency, input gaps, backpressure at bin 6
      for (int i = 0; i < NP; i++) begin
         stim_re[i] = DW'(2 * i + 1);
         stim_im[i] = DW'(31 - 2 * i);
      end
      out_hs = 0;
      drive_frame(1'b1, 1'b0);
      chk("xn_slot5_real", $signed(xn_real[DW*5 +: DW]), 11);
      chk("xn_slot5_imag", $signed(xn_imag[DW*5 +: DW]), 21);
      chk("busy_after_load", busy, 1);
      drain(6, 5);
      chk("latency_rise", rise_cyc - in_hs_edge, 3);
      check_order();
      chk("bin1_real", got_re[1], 9);
      chk("bin1_imag", got_im[1], 23);
      chk("bin15_real", got_re[15], 31);
      chk("bin15_imag", got_im[15], 1);
      chk("bin15_last", got_last[15], 1);
      chk("bin14_last", got_last[14], 0);
      @(negedge clk);
      chk("ready_after_unload", s_ready, 1);
      @(posedge clk);
      #1;

      // Frame 2: reset while bin 9 is offered
      for (int i = 0; i < NP; i++) begin
         stim_re[i] = DW'($urandom);
         stim_im[i] = DW'($urandom);
      end
      out_hs = 0;
      drive_frame(1'b0, 1'b0);
      m_ready = 1'b1;
      guard = 0;
      while (!(m_valid && m_index == 4'd9) && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("reach_bin9", m_index, 9);
      rst = 1'b1;
      #1;
      chk("async_m_valid", m_valid, 0);
      chk("async_s_ready", s_ready, 1);
      chk("async_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("post_rst_xn_zero", (xn_real == '0) && (xn_imag == '0), 1);
      chk("post_rst_index", m_index, 0);
      @(posedge clk);
      #1;

      // Frame 3: signed extremes after reset
      for (int i = 0; i < NP; i++) begin
         stim_re[i] = DW'(i - 8);
         stim_im[i] = DW'(127 - 17 * i);
      end
      out_hs = 0;
      drive_frame(1'b0, 1'b0);
      drain(-1, 0);
      check_order();
      chk("f3_bin4_real", got_re[4], -7);
      chk("f3_bin4_imag", got_im[4], 110);
      chk("f3_bin2_real", got_re[2], 0);
      chk("f3_bin2_imag", got_im[2], -9);
      chk("f3_bin15_real", got_re[15], 7);
      chk("f3_bin15_imag", got_im[15], -128);
      @(posedge clk);
      #1;

      // Frames 4 and 5 back to back, full throughput
      m_ready = 1'b1;
      for (int i = 0; i < NP; i++) begin
         stim_re[i] = DW'($urandom);
         stim_im[i] = DW'($urandom);
      end
      out_hs = 0;
      drive_frame(1'b0, 1'b1);
      for (int i = 0; i < NP; i++) begin
         stim_re[i] = DW'($urandom);
         stim_im[i] = DW'($urandom);
      end
      drive_frame(1'b0, 1'b1);
      chk("f4_handshakes", out_hs, NP);
      l4 = last_hs_edge;
      out_hs = 0;
      drain(-1, 0);
      s_valid = 1'b0;
      chk("b2b_period", rise_cyc - l4, 16 + PL + 1);
      check_order();
      repeat (4) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      n_bad++;
      $display("FAIL watchdog: simulation did not complete, required completion before time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
